// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, 16x-style oversampled start detect, mid-bit data/stop sampling.
// Optional even-parity bit between data and stop is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  logic                 rx_meta;
  logic                 rx_s;
  logic [2:0]           state;
  logic [2:0]           state_d;
  logic [TICK_W-1:0]    tick_cnt;
  logic [TICK_W-1:0]    tick_d;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d;
  logic                 ferr_d;
  logic                 perr_d;
`ifdef UART_RX_PARITY_EN
  logic                 parity_q;
  logic                 parity_d;
`endif

  // Metastability guard on the asynchronous line; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Next-state and output decode; everything holds unless an oversample tick arrives.
  always_comb begin
    state_d = state;
    tick_d  = tick_cnt;
    bit_d   = bit_cnt;
    shift_d = shift_q;
    data_d  = rx_data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_d = parity_q;
`endif
    if (rx_en) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_cnt + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_cnt + BIT_ONE;
            end
          end else begin
            tick_d = tick_cnt + TICK_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_d   = '0;
            parity_d = rx_s;
            state_d  = STOP;
          end else begin
            tick_d = tick_cnt + TICK_ONE;
          end
        end
`endif
        STOP: begin
          // Leaving at mid stop bit lets a back-to-back start edge be caught.
          if (tick_cnt == TICK_LAST) begin
            tick_d = '0;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_d  = ^{shift_q, parity_q};
`endif
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            tick_d = tick_cnt + TICK_ONE;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; pulses self-clear every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_q       <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      tick_cnt      <= tick_d;
      bit_cnt       <= bit_d;
      shift_q       <= shift_d;
      rx_data       <= data_d;
      rx_valid      <= valid_d;
      rx_frame_err  <= ferr_d;
      rx_parity_err <= perr_d;
      rx_busy       <= (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected events, a monitor pops on each pulse.
module tb_uart_rx;

  localparam int unsigned DIV      = 27;
  localparam int unsigned OS       = 16;
  localparam int unsigned BIT_CLKS = DIV * OS;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx_en;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_busy;

  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t e;
  logic prev_pulse;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_en         (rx_en),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_busy       (rx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int cnt;
    cnt   = 0;
    rx_en = 1'b0;
    forever begin
      @(negedge clk);
      rx_en = (cnt == 0);
      cnt   = (cnt == DIV - 1) ? 0 : cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_bit);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  task automatic expect_ev(input logic ferr, input logic [7:0] d, input logic perr);
    exp_t x;
    x.ferr = ferr;
    x.data = d;
    x.perr = perr;
    sb.push_back(x);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},  32'(rx_data), 32'h0);
    chk({tag, "_valid"}, 32'(rx_valid), 32'h0);
    chk({tag, "_ferr"},  32'(rx_frame_err), 32'h0);
    chk({tag, "_perr"},  32'(rx_parity_err), 32'h0);
    chk({tag, "_busy"},  32'(rx_busy), 32'h0);
  endtask

  // Monitor: every pulse must be one clock wide and match the head of the scoreboard.
  initial begin
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_pulse)
        chk("pulse_width", 32'({rx_valid, rx_frame_err, rx_parity_err}), 32'h0);
      if ((rx_valid || rx_frame_err || rx_parity_err) && !prev_pulse) begin
        chk("valid_ferr_exclusive", 32'(rx_valid & rx_frame_err), 32'h0);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'({rx_valid, rx_frame_err, rx_data}), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("ev_valid", 32'(rx_valid), 32'(!e.ferr));
          chk("ev_ferr",  32'(rx_frame_err), 32'(e.ferr));
          chk("ev_data",  32'(rx_data), 32'(e.data));
          chk("ev_perr",  32'(rx_parity_err), 32'(e.perr));
        end
      end
      prev_pulse = rx_valid | rx_frame_err | rx_parity_err;
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    rx     = 1'b1;
    wait_clks(5);
    chk_reset_outputs("por");
    rst = 1'b0;
    wait_clks(BIT_CLKS);

    // Plain frame
    expect_ev(1'b0, 8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1);
    wait_clks(2 * BIT_CLKS);
    chk("a5_busy_idle", 32'(rx_busy), 32'h0);
    chk("a5_data_hold", 32'(rx_data), 32'hA5);

    // Glitch shorter than half a bit is rejected
    rx = 1'b0;
    wait_clks(4 * DIV);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    chk("false_start_busy", 32'(rx_busy), 32'h0);
    expect_ev(1'b0, 8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1);
    wait_clks(BIT_CLKS);

    // Framing error, then line held low as a break
    expect_ev(1'b1, 8'h3C, 1'b0);
    send_frame(8'h55, 1'b0);
    wait_clks(20 * DIV);
    chk("break_busy", 32'(rx_busy), 32'h1);
    wait_clks(20 * DIV);
    chk("break_busy_late", 32'(rx_busy), 32'h1);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    chk("break_released_busy", 32'(rx_busy), 32'h0);
    chk("ferr_data_kept", 32'(rx_data), 32'h3C);
    expect_ev(1'b0, 8'h0F, 1'b0);
    send_frame(8'h0F, 1'b1);
    wait_clks(BIT_CLKS);

    // Back-to-back frames, no idle gap
    expect_ev(1'b0, 8'h00, 1'b0);
    expect_ev(1'b0, 8'hFF, 1'b0);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clks(BIT_CLKS);
    chk("b2b_last_data", 32'(rx_data), 32'hFF);

    // Reset in the middle of bit 4 of 0x81
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b0;
    wait_clks(BIT_CLKS / 2);
    chk("midframe_busy", 32'(rx_busy), 32'h1);
    rst = 1'b1;
    wait_clks(2);
    chk_reset_outputs("midrst");
    rx = 1'b1;
    wait_clks(10);
    rst = 1'b0;
    wait_clks(2 * BIT_CLKS);
    chk("post_rst_busy", 32'(rx_busy), 32'h0);
    expect_ev(1'b0, 8'h7E, 1'b0);
    send_frame(8'h7E, 1'b1);
    wait_clks(BIT_CLKS);
    chk("post_rst_data", 32'(rx_data), 32'h7E);

`ifdef UART_RX_PARITY_EN
    expect_ev(1'b0, 8'h07, 1'b0);
    send_frame_par(8'h07, 1'b1);
    wait_clks(BIT_CLKS);
    expect_ev(1'b0, 8'h07, 1'b1);
    send_frame_par(8'h07, 1'b0);
    wait_clks(BIT_CLKS);
`endif

    wait_clks(2 * BIT_CLKS);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
